// File: rtl/afifo_arb_pkg.sv
// Shared types for the async-FIFO drain arbiter.
// Holds the FSM encoding and the burst counter width.
package afifo_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE_E,
        ARB_BURST_E,
        ARB_HOLD_E
    } arb_state_t;

    localparam int unsigned BURST_CNT_W = 8;

endpackage

// File: rtl/afifo_drain_arbiter_if.sv
// Egress valid/ready stream carrying a word and its channel tag.
// The arbiter drives it as master, the sink as slave.
interface afifo_drain_arbiter_if #(
    parameter int DATA_WIDTH_P = 32,
    parameter int CH_WIDTH_P   = 2
);

    logic                    egr_valid;
    logic                    egr_ready;
    logic [DATA_WIDTH_P-1:0] egr_data;
    logic [CH_WIDTH_P-1:0]   egr_channel;

    modport master (
        output egr_valid,
        output egr_data,
        output egr_channel,
        input  egr_ready
    );

    modport slave (
        input  egr_valid,
        input  egr_data,
        input  egr_channel,
        output egr_ready
    );

endinterface

// File: rtl/afifo_arb_skid.sv
// Two-entry {channel,data} egress buffer.
// Outputs come straight from the head register.
module afifo_arb_skid #(
    parameter int CW = 2,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [CW-1:0] push_ch,
    input  logic [DW-1:0] push_data,
    input  logic          pop_ready,
    output logic [1:0]    occ,
    output logic          egr_valid,
    output logic [DW-1:0] egr_data,
    output logic [CW-1:0] egr_channel
);

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [DW-1:0] data;
    } entry_t;

    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    entry_t     in_e;
    logic [1:0] occ_q, occ_d;
    logic       pop;

    assign egr_valid   = (occ_q != 2'd0);
    assign egr_data    = head_q.data;
    assign egr_channel = head_q.ch;
    assign occ         = occ_q;
    assign pop         = egr_valid && pop_ready;

    always_comb begin
        in_e   = '{ch: push_ch, data: push_data};
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = in_e;
                else               tail_d = in_e;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // push+pop at 1 keeps occupancy at 1
                if (occ_q == 2'd1) begin
                    head_d = in_e;
                end else begin
                    head_d = tail_q;
                    tail_d = in_e;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: rtl/afifo_drain_arbiter.sv
// Round-robin burst scheduler draining several async FIFO read ports
// into one tagged valid/ready egress stream.
module afifo_drain_arbiter
    import afifo_arb_pkg::*;
#(
    parameter int NR_OF_CH_P   = 4,
    parameter int DATA_WIDTH_P = 32,
    parameter int BURST_LEN_P  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [NR_OF_CH_P-1:0] fifo_read_en,
    input  logic [NR_OF_CH_P*DATA_WIDTH_P-1:0] fifo_data,
    input  logic [NR_OF_CH_P-1:0] fifo_valid,
    input  logic [NR_OF_CH_P-1:0] fifo_empty,
    input  logic [NR_OF_CH_P-1:0] cr_ch_enable,
    afifo_drain_arbiter_if.master egr,
    output logic                 sr_busy,
    output logic                 sr_protocol_err
);

    localparam int CH_WIDTH_C = $clog2(NR_OF_CH_P);
    localparam logic [BURST_CNT_W-1:0] BURST_LEN_C =
        BURST_CNT_W'(BURST_LEN_P);

    arb_state_t              state_q, state_d;
    logic [CH_WIDTH_C-1:0]   gnt_q, gnt_d;
    logic [CH_WIDTH_C-1:0]   rr_q, rr_d;
    logic [BURST_CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic                    infl_q, infl_d;
    logic [CH_WIDTH_C-1:0]   infl_ch_q, infl_ch_d;
    logic                    perr_q, perr_d;

    logic [NR_OF_CH_P-1:0]   eligible;
    logic [NR_OF_CH_P-1:0]   exp_vld;
    logic                    sel_found;
    logic [CH_WIDTH_C-1:0]   sel_ch;
    int                      idx;
    logic                    gnt_elig;
    logic                    credit;
    logic                    rd_en;
    logic                    push;
    logic [DATA_WIDTH_P-1:0] push_data;
    logic [1:0]              occ;

    assign eligible = cr_ch_enable & ~fifo_empty;
    assign gnt_elig = eligible[gnt_q];
    assign cnt_inc  = cnt_q + 1'b1;

    // buffer slots are reserved for words already requested
    assign credit = (occ == 2'd0) || ((occ == 2'd1) && !infl_q);
    assign rd_en  = (state_q == ARB_BURST_E) && gnt_elig && credit;

    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        idx       = 0;
        for (int k = 0; k < NR_OF_CH_P; k++) begin
            idx = (int'(rr_q) + k) % NR_OF_CH_P;
            if (!sel_found && eligible[idx]) begin
                sel_found = 1'b1;
                sel_ch    = CH_WIDTH_C'(idx);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NR_OF_CH_P; i++) begin
            fifo_read_en[i] = rd_en && (gnt_q == CH_WIDTH_C'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB_IDLE_E: begin
                if (sel_found) begin
                    gnt_d   = sel_ch;
                    cnt_d   = '0;
                    state_d = ARB_BURST_E;
                end
            end
            ARB_BURST_E: begin
                if (rd_en) cnt_d = cnt_inc;
                if ((rd_en && (cnt_inc == BURST_LEN_C)) || !gnt_elig) begin
                    state_d = ARB_HOLD_E;
                end
            end
            ARB_HOLD_E: begin
                if (gnt_q == CH_WIDTH_C'(NR_OF_CH_P - 1)) rr_d = '0;
                else                                      rr_d = gnt_q + 1'b1;
                state_d = ARB_IDLE_E;
            end
            default: state_d = ARB_IDLE_E;
        endcase
    end

    always_comb begin
        exp_vld = '0;
        if (infl_q) exp_vld[infl_ch_q] = 1'b1;
        push      = infl_q && fifo_valid[infl_ch_q];
        push_data = fifo_data[int'(infl_ch_q)*DATA_WIDTH_P +: DATA_WIDTH_P];
        perr_d    = perr_q || (|(fifo_valid & ~exp_vld));
        infl_d    = rd_en;
        infl_ch_d = rd_en ? gnt_q : infl_ch_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE_E;
            gnt_q     <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            infl_q    <= 1'b0;
            infl_ch_q <= '0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            infl_q    <= infl_d;
            infl_ch_q <= infl_ch_d;
            perr_q    <= perr_d;
        end
    end

    afifo_arb_skid #(
        .CW (CH_WIDTH_C),
        .DW (DATA_WIDTH_P)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_ch     (infl_ch_q),
        .push_data   (push_data),
        .pop_ready   (egr.egr_ready),
        .occ         (occ),
        .egr_valid   (egr.egr_valid),
        .egr_data    (egr.egr_data),
        .egr_channel (egr.egr_channel)
    );

    assign sr_busy = (state_q != ARB_IDLE_E) || (occ != 2'd0) || infl_q;
    assign sr_protocol_err = perr_q;

endmodule

// File: tb/tb_afifo_drain_arbiter.sv
// Bench for afifo_drain_arbiter: FIFO models, egress monitor and
// per-channel sequence scoreboard, directed plus random phases.
module tb_afifo_drain_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 32;

    typedef struct {
        logic [3:0]  ch;
        logic [31:0] d;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NCH-1:0]   fifo_read_en;
    logic [NCH*DW-1:0] fifo_data;
    logic [NCH-1:0]   fifo_valid;
    logic [NCH-1:0]   fifo_empty;
    logic [NCH-1:0]   cr_ch_enable;
    logic [NCH-1:0]   vld_r;
    logic [NCH-1:0]   force_vld;
    logic             sr_busy;
    logic             sr_protocol_err;

    logic [31:0] mem [NCH][256];
    logic [31:0] wr_ptr [NCH];
    logic [31:0] rd_ptr [NCH];
    logic [31:0] seq_r [NCH];
    int          strobe_n [NCH];
    int          onehot_bad;
    obs_t        obs [$];
    int          rd_idx;
    int          n_checks;
    int          n_errors;

    afifo_drain_arbiter_if #(.DATA_WIDTH_P(DW), .CH_WIDTH_P(2)) egr_if ();

    afifo_drain_arbiter #(
        .NR_OF_CH_P   (NCH),
        .DATA_WIDTH_P (DW),
        .BURST_LEN_P  (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fifo_read_en    (fifo_read_en),
        .fifo_data       (fifo_data),
        .fifo_valid      (fifo_valid),
        .fifo_empty      (fifo_empty),
        .cr_ch_enable    (cr_ch_enable),
        .egr             (egr_if),
        .sr_busy         (sr_busy),
        .sr_protocol_err (sr_protocol_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NCH; i++) fifo_empty[i] = (rd_ptr[i] == wr_ptr[i]);
    end

    assign fifo_valid = vld_r | force_vld;

    // read port model: registered data one cycle after the strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) rd_ptr[i] <= wr_ptr[i];
            vld_r     <= '0;
            fifo_data <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (fifo_read_en[i] && (rd_ptr[i] != wr_ptr[i])) begin
                    fifo_data[i*DW +: DW] <= mem[i][rd_ptr[i][7:0]];
                    rd_ptr[i] <= rd_ptr[i] + 1;
                    vld_r[i]  <= 1'b1;
                end else begin
                    vld_r[i]  <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (egr_if.egr_valid && egr_if.egr_ready)
                obs.push_back('{ch: {2'b00, egr_if.egr_channel},
                                d: egr_if.egr_data});
            for (int i = 0; i < NCH; i++)
                if (fifo_read_en[i]) strobe_n[i]++;
            if ($countones(fifo_read_en) > 1) onehot_bad++;
        end
    end

    function automatic logic [31:0] gen(input logic [3:0] ch,
                                        input logic [31:0] s);
        return {4'hD, ch, s[7:0], s[15:0] ^ 16'hBEEF};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            mem[ch][wr_ptr[ch][7:0]] = gen(4'(ch), wr_ptr[ch]);
            wr_ptr[ch] = wr_ptr[ch] + 1;
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_eq({tag, "_rst_valid"}, 64'(egr_if.egr_valid), 0);
        check_eq({tag, "_rst_data"}, 64'(egr_if.egr_data), 0);
        check_eq({tag, "_rst_rd_en"}, 64'(fifo_read_en), 0);
        check_eq({tag, "_rst_busy"}, 64'(sr_busy), 0);
        check_eq({tag, "_rst_perr"}, 64'(sr_protocol_err), 0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) seq_r[i] = wr_ptr[i];
        rd_idx = obs.size();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!(!sr_busy && ((cr_ch_enable & ~fifo_empty) == '0))
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_idle_timeout"}, 64'(n >= 3000), 0);
        step();
    endtask

    task automatic expect_word(input string tag, input logic [3:0] ch);
        logic [3:0]  gch;
        logic [31:0] gd;
        gch = 4'hF;
        gd  = '0;
        if (rd_idx < obs.size()) begin
            gch = obs[rd_idx].ch;
            gd  = obs[rd_idx].d;
        end
        rd_idx++;
        check_eq({tag, "_ch"}, 64'(gch), 64'(ch));
        check_eq({tag, "_data"}, 64'(gd), 64'(gen(ch, seq_r[ch])));
        seq_r[ch] = seq_r[ch] + 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, n, start, stab_bad;
        for (int i = 0; i < NCH; i++) wr_ptr[i] = '0;
        force_vld        = '0;
        cr_ch_enable     = 4'hF;
        egr_if.egr_ready = 1'b1;
        n_checks = 0;
        n_errors = 0;
        step();
        do_reset("init");

        // burst drain of a single channel
        push(0, 6);
        wait_idle("t1");
        check_eq("t1_count", 64'(obs.size() - rd_idx), 6);
        for (int k = 0; k < 6; k++) expect_word("t1", 4'd0);

        // round robin over four full channels
        do_reset("t2");
        for (int c = 0; c < NCH; c++) push(c, 8);
        wait_idle("t2");
        check_eq("t2_count", 64'(obs.size() - rd_idx), 32);
        for (int k = 0; k < 32; k++) expect_word("t2", 4'((k / 4) % 4));

        // backpressure
        do_reset("t3");
        egr_if.egr_ready = 1'b0;
        b = strobe_n[1];
        stab_bad = 0;
        push(1, 5);
        repeat (20) begin
            @(negedge clk);
            if (egr_if.egr_valid && egr_if.egr_data !== gen(4'd1, seq_r[1]))
                stab_bad++;
        end
        check_eq("t3_strobes", 64'(strobe_n[1] - b), 2);
        check_eq("t3_valid", 64'(egr_if.egr_valid), 1);
        check_eq("t3_head", 64'(egr_if.egr_data), 64'(gen(4'd1, seq_r[1])));
        check_eq("t3_stable", 64'(stab_bad), 0);
        step();
        egr_if.egr_ready = 1'b1;
        wait_idle("t3");
        check_eq("t3_count", 64'(obs.size() - rd_idx), 5);
        for (int k = 0; k < 5; k++) expect_word("t3", 4'd1);

        // channel disabled mid-burst
        do_reset("t4");
        start = rd_idx;
        b = strobe_n[2];
        push(2, 6);
        push(3, 3);
        n = 0;
        while ((strobe_n[2] - b) < 2 && n < 200) begin
            step();
            n++;
        end
        check_eq("t4_wait", 64'(n >= 200), 0);
        cr_ch_enable[2] = 1'b0;
        wait_idle("t4a");
        check_eq("t4_strobes", 64'(strobe_n[2] - b), 2);
        expect_word("t4a", 4'd2);
        expect_word("t4a", 4'd2);
        for (int k = 0; k < 3; k++) expect_word("t4b", 4'd3);
        cr_ch_enable[2] = 1'b1;
        wait_idle("t4c");
        for (int k = 0; k < 4; k++) expect_word("t4c", 4'd2);
        check_eq("t4_count", 64'(obs.size() - start), 9);

        // stray fifo_valid
        do_reset("t5");
        start = rd_idx;
        force_vld = 4'b0010;
        step();
        force_vld = '0;
        @(negedge clk);
        check_eq("t5_perr", 64'(sr_protocol_err), 1);
        check_eq("t5_valid", 64'(egr_if.egr_valid), 0);
        repeat (6) step();
        check_eq("t5_sticky", 64'(sr_protocol_err), 1);
        check_eq("t5_noword", 64'(obs.size() - start), 0);

        // reset mid-burst restarts the pointer at ch0
        do_reset("t6");
        b = strobe_n[3];
        push(2, 2);
        push(3, 8);
        n = 0;
        while ((strobe_n[3] - b) < 2 && n < 200) begin
            step();
            n++;
        end
        check_eq("t6_wait", 64'(n >= 200), 0);
        expect_word("t6a", 4'd2);
        expect_word("t6a", 4'd2);
        do_reset("t6");
        push(0, 2);
        push(3, 2);
        wait_idle("t6b");
        check_eq("t6_count", 64'(obs.size() - rd_idx), 4);
        expect_word("t6b", 4'd0);
        expect_word("t6b", 4'd0);
        expect_word("t6b", 4'd3);
        expect_word("t6b", 4'd3);

        // random traffic, ready and enable churn
        do_reset("rnd");
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NCH; c++) push(c, $urandom_range(0, 10));
            repeat (80) begin
                egr_if.egr_ready = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0)
                    cr_ch_enable = 4'($urandom);
                step();
            end
            egr_if.egr_ready = 1'b1;
            cr_ch_enable = 4'hF;
            wait_idle("rnd");
            while (rd_idx < obs.size()) begin
                check_eq("rnd_data", 64'(obs[rd_idx].d),
                         64'(gen(obs[rd_idx].ch, seq_r[obs[rd_idx].ch])));
                seq_r[obs[rd_idx].ch] = seq_r[obs[rd_idx].ch] + 1;
                rd_idx++;
            end
            for (int c = 0; c < NCH; c++)
                check_eq("rnd_drained", 64'(seq_r[c]), 64'(wr_ptr[c]));
        end
        check_eq("rnd_perr", 64'(sr_protocol_err), 0);
        check_eq("onehot", 64'(onehot_bad), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
